// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences a fixed-latency single-port data memory behind
// the MEM stage. A request from the EXE/MEM register is latched in IDLE, the
// memory is driven with stable controls for WAIT_CYCLES cycles (ACCESS), and
// a one-cycle DONE retires the access with a ready pulse.
//
// Handshake: the pipeline presents MEM_R_en/MEM_W_en with address/data and
// holds them while freeze is high; an access retires in the cycle ready is
// high (freeze low), and the pipeline advances at the end of that cycle.
// Inputs seen during DONE belong to the retiring instruction and are ignored.
//
// Optional feature macro: MEM_POSTED_WRITE_EN (posted writes). When defined,
// a write does not stall the pipeline; it runs in the background and returns
// straight to IDLE without a DONE cycle or ready pulse. A request arriving
// while a posted write is still in ACCESS is held off with freeze until IDLE.
module mem_access_ctrl #(
   parameter int WAIT_CYCLES = 3,
   parameter int ADDR_BASE   = 1024,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_R_en,
   input  logic              MEM_W_en,
   input  logic [31:0]       address,
   input  logic [DATA_W-1:0] data,
   output logic              freeze,
   output logic              ready,
   output logic [DATA_W-1:0] MEM_result,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_en,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [31:0] BASE     = 32'(ADDR_BASE);
   localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t      state;
   logic        op_read;
   logic [3:0]  counter;
   logic        req;
   logic [31:0] word_addr;

   // Any enable is a request; the byte address is rebased and divided by 4
   // with plain modulo-2^32 arithmetic (low two bits dropped, no alignment check).
   assign req       = MEM_R_en | MEM_W_en;
   assign word_addr = (address - BASE) >> 2;
   assign fsm_state = state;

   // Stall request: combinational so the pipeline holds in the request cycle.
   always_comb begin
      freeze = 1'b0;
      if (rst) begin
         case (state)
`ifdef MEM_POSTED_WRITE_EN
            S_IDLE:   freeze = MEM_R_en;
            S_ACCESS: freeze = op_read | req;
`else
            S_IDLE:   freeze = req;
            S_ACCESS: freeze = 1'b1;
`endif
            default:  freeze = 1'b0;
         endcase
      end
   end

   // Access sequencer with registered memory controls, ready and read result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         op_read    <= 1'b0;
         counter    <= 4'd0;
         ready      <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= '0;
         MEM_result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               ready <= 1'b0;
               if (req) begin
                  // Read wins when both enables are high; the write is dropped.
                  op_read   <= MEM_R_en;
                  mem_addr  <= word_addr;
                  mem_wdata <= data;
                  counter   <= CNT_INIT;
                  mem_en    <= 1'b1;
                  mem_we    <= ~MEM_R_en;
                  state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (counter == 4'd0) begin
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  if (op_read) begin
                     MEM_result <= mem_rdata;
                  end
`ifdef MEM_POSTED_WRITE_EN
                  if (op_read) begin
                     ready <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state <= S_IDLE;
                  end
`else
                  ready <= 1'b1;
                  state <= S_DONE;
`endif
               end else begin
                  counter <= counter - 4'd1;
               end
            end
            S_DONE: begin
               ready <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               ready  <= 1'b0;
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with WAIT_CYCLES=3, ADDR_BASE=1024.
// Cycle c starts 1 time unit after a rising edge (inputs driven there);
// outputs are sampled on the following falling edge.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        MEM_R_en;
   logic        MEM_W_en;
   logic [31:0] address;
   logic [31:0] data;
   logic        freeze;
   logic        ready;
   logic [31:0] MEM_result;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic [1:0]  fsm_state;

   int pass_cnt;
   int total_cnt;

   mem_access_ctrl #(
      .WAIT_CYCLES(3),
      .ADDR_BASE  (1024),
      .DATA_W     (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .MEM_R_en  (MEM_R_en),
      .MEM_W_en  (MEM_W_en),
      .address   (address),
      .data      (data),
      .freeze    (freeze),
      .ready     (ready),
      .MEM_result(MEM_result),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .fsm_state (fsm_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance to the start of the next cycle
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; MEM_R_en = 1'b0; MEM_W_en = 1'b1;
      address = 32'd1028; data = 32'h1111_2222; mem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({freeze, ready, mem_en, mem_we} !== 4'b0000) $display("FAIL reset_ctl got=%b want=0000", {freeze, ready, mem_en, mem_we});
      else pass_cnt++;
      total_cnt++;
      if ({MEM_result, mem_addr, mem_wdata} !== 96'd0) $display("FAIL reset_data got=%h %h %h want=0", MEM_result, mem_addr, mem_wdata);
      else pass_cnt++;
      next_cycle();
      MEM_W_en = 1'b0;
      rst = 1'b1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      total_cnt++;
      if (fsm_state !== 2'd0 || mem_en !== 1'b0 || freeze !== 1'b0) $display("FAIL post_reset_idle got=st%0d en%b fr%b want=st0 en0 fr0", fsm_state, mem_en, freeze);
      else pass_cnt++;
      next_cycle();
   endtask

   task automatic test_write();
      MEM_W_en = 1'b1; address = 32'd1028; data = 32'hDEAD_BEEF;
      for (int c = 0; c <= 4; c++) begin
         @(negedge clk);
         total_cnt++;
         if (freeze !== (c <= 3)) $display("FAIL wr_freeze c%0d got=%b want=%b", c, freeze, (c <= 3));
         else pass_cnt++;
         total_cnt++;
         if ({mem_en, mem_we} !== {2{(c >= 1 && c <= 3)}}) $display("FAIL wr_en_we c%0d got=%b%b", c, mem_en, mem_we);
         else pass_cnt++;
         total_cnt++;
         if (ready !== (c == 4)) $display("FAIL wr_ready c%0d got=%b want=%b", c, ready, (c == 4));
         else pass_cnt++;
         if (c == 2) begin
            total_cnt++;
            if (mem_addr !== 32'd1 || mem_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_addr_data got=%h %h want=1 deadbeef", mem_addr, mem_wdata);
            else pass_cnt++;
         end
         if (c == 4) begin
            total_cnt++;
            if (MEM_result !== 32'd0) $display("FAIL wr_result got=%h want=0", MEM_result);
            else pass_cnt++;
         end
         next_cycle();
      end
      MEM_W_en = 1'b0;
   endtask

   task automatic test_read();
      MEM_R_en = 1'b1; address = 32'd1028; data = 32'h0;
      for (int c = 0; c <= 4; c++) begin
         mem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
         @(negedge clk);
         total_cnt++;
         if (freeze !== (c <= 3) || ready !== (c == 4)) $display("FAIL rd_fr_rdy c%0d got=%b%b", c, freeze, ready);
         else pass_cnt++;
         total_cnt++;
         if (mem_en !== (c >= 1 && c <= 3) || mem_we !== 1'b0) $display("FAIL rd_en_we c%0d got=%b%b", c, mem_en, mem_we);
         else pass_cnt++;
         total_cnt++;
         if (MEM_result !== ((c == 4) ? 32'hDEAD_BEEF : 32'd0)) $display("FAIL rd_result c%0d got=%h", c, MEM_result);
         else pass_cnt++;
         next_cycle();
      end
      MEM_R_en = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic test_both_enables();
      MEM_R_en = 1'b1; MEM_W_en = 1'b1; address = 32'd1032; data = 32'h5555_AAAA;
      for (int c = 0; c <= 4; c++) begin
         mem_rdata = (c == 3) ? 32'h1234_5678 : 32'h0;
         @(negedge clk);
         total_cnt++;
         if (mem_we !== 1'b0 || mem_en !== (c >= 1 && c <= 3)) $display("FAIL both_we c%0d got=en%b we%b", c, mem_en, mem_we);
         else pass_cnt++;
         if (c == 1) begin
            total_cnt++;
            if (mem_addr !== 32'd2) $display("FAIL both_addr got=%h want=2", mem_addr);
            else pass_cnt++;
         end
         if (c == 4) begin
            total_cnt++;
            if (MEM_result !== 32'h1234_5678 || ready !== 1'b1) $display("FAIL both_result got=%h rdy%b want=12345678 rdy1", MEM_result, ready);
            else pass_cnt++;
         end
         next_cycle();
      end
      MEM_R_en = 1'b0; MEM_W_en = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c <= 9; c++) begin
         MEM_R_en  = (c <= 4);
         MEM_W_en  = (c >= 5);
         address   = (c <= 4) ? 32'd1036 : 32'd1040;
         data      = 32'h7777_0000;
         mem_rdata = (c == 3) ? 32'hCAFE_F00D : 32'h0;
         @(negedge clk);
         total_cnt++;
         if (freeze !== ((c <= 3) || (c >= 5 && c <= 8))) $display("FAIL b2b_freeze c%0d got=%b", c, freeze);
         else pass_cnt++;
         total_cnt++;
         if (mem_en !== ((c >= 1 && c <= 3) || (c >= 6 && c <= 8)) || mem_we !== (c >= 6 && c <= 8)) $display("FAIL b2b_en_we c%0d got=%b%b", c, mem_en, mem_we);
         else pass_cnt++;
         total_cnt++;
         if (ready !== (c == 4 || c == 9)) $display("FAIL b2b_ready c%0d got=%b", c, ready);
         else pass_cnt++;
         if (c == 6) begin
            total_cnt++;
            if (mem_addr !== 32'd4 || mem_wdata !== 32'h7777_0000) $display("FAIL b2b_addr got=%h %h want=4 77770000", mem_addr, mem_wdata);
            else pass_cnt++;
         end
         if (c >= 4) begin
            total_cnt++;
            if (MEM_result !== 32'hCAFE_F00D) $display("FAIL b2b_result c%0d got=%h want=cafef00d", c, MEM_result);
            else pass_cnt++;
         end
         next_cycle();
      end
      MEM_R_en = 1'b0; MEM_W_en = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic test_reset_mid_write();
      MEM_W_en = 1'b1; address = 32'd1100; data = 32'hABCD_0123;
      next_cycle();
      next_cycle();
      @(negedge clk);
      total_cnt++;
      if (mem_we !== 1'b1) $display("FAIL rstmid_pre_we got=%b want=1", mem_we);
      else pass_cnt++;
      next_cycle();
      rst = 1'b0;
      #1;
      total_cnt++;
      if (mem_we !== 1'b0 || freeze !== 1'b0 || mem_en !== 1'b0) $display("FAIL rstmid_ctl got=we%b fr%b en%b want=0", mem_we, freeze, mem_en);
      else pass_cnt++;
      total_cnt++;
      if (fsm_state !== 2'd0 || MEM_result !== 32'd0) $display("FAIL rstmid_state got=st%0d res=%h want=st0 res=0", fsm_state, MEM_result);
      else pass_cnt++;
      MEM_W_en = 1'b0;
      next_cycle();
      rst = 1'b1;
      next_cycle();
   endtask

`ifdef MEM_POSTED_WRITE_EN
   task automatic test_posted_write();
      for (int c = 0; c <= 9; c++) begin
         MEM_W_en  = (c == 0);
         MEM_R_en  = (c >= 1 && c <= 8);
         address   = 32'd1028;
         data      = 32'h0F0F_0F0F;
         mem_rdata = (c == 7) ? 32'h600D_CAFE : 32'h0;
         @(negedge clk);
         total_cnt++;
         if (freeze !== (c >= 1 && c <= 7)) $display("FAIL post_freeze c%0d got=%b", c, freeze);
         else pass_cnt++;
         total_cnt++;
         if (ready !== (c == 8)) $display("FAIL post_ready c%0d got=%b", c, ready);
         else pass_cnt++;
         total_cnt++;
         if (mem_en !== ((c >= 1 && c <= 3) || (c >= 5 && c <= 7)) || mem_we !== (c >= 1 && c <= 3)) $display("FAIL post_en_we c%0d got=%b%b", c, mem_en, mem_we);
         else pass_cnt++;
         if (c == 8) begin
            total_cnt++;
            if (MEM_result !== 32'h600D_CAFE) $display("FAIL post_result got=%h want=600dcafe", MEM_result);
            else pass_cnt++;
         end
         next_cycle();
      end
      MEM_R_en = 1'b0; MEM_W_en = 1'b0; mem_rdata = 32'h0;
   endtask
`endif

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      test_reset();
      test_write();
      test_read();
      test_both_enables();
      test_back_to_back();
`ifdef MEM_POSTED_WRITE_EN
      test_posted_write();
`endif
      test_reset_mid_write();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
